// File: rtl/branch_stack.sv
// Branch checkpoint stack: one-hot slots holding free-list / ROB-tail snapshots with dependency masks.
// Optional macro BRANCH_STACK_RETIRE_MERGE_EN ORs same-cycle retirements into the restored free list.
`ifndef N
`define N 2
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif

module branch_stack #(
    parameter int DEPTH     = 4,
    parameter int N         = `N,
    parameter int PREGS     = `PHYS_REG_SZ_R10K,
    parameter int ROB_IDX_W = 5,
    localparam int PR_IDX_W = $clog2(PREGS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push_valid,
    input  logic [PREGS-1:0]            push_free_list,
    input  logic [ROB_IDX_W-1:0]        push_rob_tail,
    output logic [DEPTH-1:0]            push_tag,
    output logic                        stack_full,
    output logic [DEPTH-1:0]            branch_mask,
    input  logic                        resolve_valid,
    input  logic [DEPTH-1:0]            resolve_tag,
    input  logic                        resolve_mispredict,
    input  logic [N*PR_IDX_W-1:0]       phys_reg_retiring,
    input  logic [`NUM_SCALAR_BITS-1:0] num_retiring_valid,
    output logic                        restore_flag,
    output logic [PREGS-1:0]            free_list_restore,
    output logic [ROB_IDX_W-1:0]        rob_tail_restore,
    output logic [DEPTH-1:0]            squash_mask
);

    logic [DEPTH-1:0]                valid_q, valid_d;
    logic [DEPTH-1:0][PREGS-1:0]     snap_q, snap_d;
    logic [DEPTH-1:0][ROB_IDX_W-1:0] tail_q, tail_d;
    logic [DEPTH-1:0][DEPTH-1:0]     dep_q, dep_d;

    logic [PREGS-1:0] retire_bits;
    logic [DEPTH-1:0] grant;
    logic [DEPTH-1:0] freed;
    logic [DEPTH-1:0] squash;
    logic             resolve_ok;
    logic             mispredict;
    logic             do_push;

    // Registers retiring this cycle; entries beyond the valid count are ignored.
    always_comb begin
        retire_bits = '0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(num_retiring_valid))
                retire_bits[phys_reg_retiring[i*PR_IDX_W +: PR_IDX_W]] = 1'b1;
        end
    end

    // Lowest-index free slot; a slot freed this cycle is still valid here, so it is not granted.
    always_comb begin
        grant = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    assign push_tag    = grant;
    assign stack_full  = &valid_q;
    assign branch_mask = valid_q;

    assign resolve_ok = resolve_valid && $onehot(resolve_tag) && |(resolve_tag & valid_q);
    assign mispredict = resolve_ok && resolve_mispredict;
    assign freed      = (resolve_ok && !resolve_mispredict) ? resolve_tag : '0;
    assign do_push    = push_valid && !stack_full && !mispredict;

    always_comb begin
        squash            = '0;
        free_list_restore = '0;
        rob_tail_restore  = '0;
        if (mispredict) begin
            squash = resolve_tag;
            for (int j = 0; j < DEPTH; j++) begin
                if (valid_q[j] && |(dep_q[j] & resolve_tag))
                    squash[j] = 1'b1;
                if (resolve_tag[j]) begin
                    free_list_restore = snap_q[j];
                    rob_tail_restore  = tail_q[j];
                end
            end
`ifdef BRANCH_STACK_RETIRE_MERGE_EN
            free_list_restore = free_list_restore | retire_bits;
`endif
        end
    end

    assign restore_flag = mispredict;
    assign squash_mask  = squash;

    always_comb begin
        valid_d = valid_q & ~freed & ~squash;
        snap_d  = snap_q;
        tail_d  = tail_q;
        dep_d   = dep_q;
        for (int j = 0; j < DEPTH; j++) begin
            if (valid_q[j])
                snap_d[j] = snap_q[j] | retire_bits;
            dep_d[j] = dep_q[j] & ~freed;
            if (do_push && grant[j]) begin
                valid_d[j] = 1'b1;
                snap_d[j]  = push_free_list | retire_bits;
                tail_d[j]  = push_rob_tail;
                dep_d[j]   = valid_q & ~freed;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            snap_q  <= '0;
            tail_q  <= '0;
            dep_q   <= '0;
        end else begin
            valid_q <= valid_d;
            snap_q  <= snap_d;
            tail_q  <= tail_d;
            dep_q   <= dep_d;
        end
    end

endmodule

// File: tb/tb_branch_stack.sv
// Bench for branch_stack: vector table, directed corner sequences, and randomized run against an age-ordered model.
module tb_branch_stack;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        push_valid;
    logic [63:0] push_free_list;
    logic [4:0]  push_rob_tail;
    logic [3:0]  push_tag;
    logic        stack_full;
    logic [3:0]  branch_mask;
    logic        resolve_valid;
    logic [3:0]  resolve_tag;
    logic        resolve_mispredict;
    logic [11:0] phys_reg_retiring;
    logic [1:0]  num_retiring_valid;
    logic        restore_flag;
    logic [63:0] free_list_restore;
    logic [4:0]  rob_tail_restore;
    logic [3:0]  squash_mask;

    int checks = 0;
    int errors = 0;

    branch_stack #(.DEPTH(4), .N(2), .PREGS(64), .ROB_IDX_W(5)) dut (
        .clock(clock), .reset(reset),
        .push_valid(push_valid), .push_free_list(push_free_list), .push_rob_tail(push_rob_tail),
        .push_tag(push_tag), .stack_full(stack_full), .branch_mask(branch_mask),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_mispredict(resolve_mispredict),
        .phys_reg_retiring(phys_reg_retiring), .num_retiring_valid(num_retiring_valid),
        .restore_flag(restore_flag), .free_list_restore(free_list_restore),
        .rob_tail_restore(rob_tail_restore), .squash_mask(squash_mask)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        pv;
        logic [63:0] pfl;
        logic [4:0]  pt;
        logic        rv;
        logic [3:0]  rtag;
        logic        rmis;
        logic [3:0]  e_tag;
        logic        e_full;
        logic [3:0]  e_mask;
        logic        e_rf;
        logic [63:0] e_flr;
        logic [4:0]  e_rtr;
        logic [3:0]  e_sq;
    } vec_t;

    vec_t tbl[8];

    // Reference model: slots carry an allocation sequence number; younger = larger number.
    bit          mv[4];
    logic [63:0] msnap[4];
    logic [4:0]  mtail[4];
    int          mseq[4];
    int          seqc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic pv, input logic [63:0] pfl, input logic [4:0] pt,
                          input logic rv, input logic [3:0] rtag, input logic rmis,
                          input logic [1:0] nrv, input logic [5:0] r0, input logic [5:0] r1);
        push_valid         = pv;
        push_free_list     = pfl;
        push_rob_tail      = pt;
        resolve_valid      = rv;
        resolve_tag        = rtag;
        resolve_mispredict = rmis;
        num_retiring_valid = nrv;
        phys_reg_retiring  = {r1, r0};
    endtask

    task automatic idle();
        set_in(1'b0, 64'd0, 5'd0, 1'b0, 4'd0, 1'b0, 2'd0, 6'd0, 6'd0);
    endtask

    task automatic push(input logic [63:0] fl, input logic [4:0] t);
        set_in(1'b1, fl, t, 1'b0, 4'd0, 1'b0, 2'd0, 6'd0, 6'd0);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        idle();
        #1;
        chk("rst_mask", 64'(branch_mask), 64'h0);
        chk("rst_tag", 64'(push_tag), 64'h1);
        chk("rst_full", 64'(stack_full), 64'h0);
        chk("rst_restore", 64'({restore_flag, rob_tail_restore, squash_mask}), 64'h0);
        chk("rst_flr", free_list_restore, 64'h0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0; msnap[i] = '0; mtail[i] = '0; mseq[i] = 0;
        end
        seqc = 0;
    endtask

    function automatic vec_t mk(input logic pv, input logic [63:0] pfl, input logic [4:0] pt,
                                input logic rv, input logic [3:0] rtag, input logic rmis,
                                input logic [3:0] e_tag, input logic e_full, input logic [3:0] e_mask,
                                input logic e_rf, input logic [63:0] e_flr, input logic [4:0] e_rtr,
                                input logic [3:0] e_sq);
        vec_t v;
        v.pv = pv; v.pfl = pfl; v.pt = pt; v.rv = rv; v.rtag = rtag; v.rmis = rmis;
        v.e_tag = e_tag; v.e_full = e_full; v.e_mask = e_mask;
        v.e_rf = e_rf; v.e_flr = e_flr; v.e_rtr = e_rtr; v.e_sq = e_sq;
        return v;
    endfunction

    task automatic random_phase(input int cycles);
        logic        pv, rv, rmis;
        logic [63:0] pfl, rb, e_flr;
        logic [4:0]  pt, e_rtr;
        logic [3:0]  rtag, e_tag, e_mask, e_sq;
        logic [1:0]  nrv;
        logic [5:0]  r0, r1;
        logic        e_full, ok, mis;
        int          ridx, slot;
        for (int c = 0; c < cycles; c++) begin
            pv   = ($urandom_range(0, 9) < 6);
            pfl  = {$urandom, $urandom};
            pt   = 5'($urandom);
            rv   = ($urandom_range(0, 1) == 1);
            rtag = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            rmis = ($urandom_range(0, 9) < 3);
            nrv  = 2'($urandom_range(0, 3));
            r0   = 6'($urandom);
            r1   = 6'($urandom);
            set_in(pv, pfl, pt, rv, rtag, rmis, nrv, r0, r1);

            e_mask = '0;
            e_tag  = '0;
            for (int i = 0; i < 4; i++) e_mask[i] = mv[i];
            e_full = &e_mask;
            slot   = -1;
            for (int i = 3; i >= 0; i--) if (!mv[i]) slot = i;
            if (slot >= 0) e_tag = 4'(1 << slot);
            rb = '0;
            if (nrv >= 1) rb[r0] = 1'b1;
            if (nrv >= 2) rb[r1] = 1'b1;
            ridx = -1;
            if (rv && $onehot(rtag))
                for (int i = 0; i < 4; i++) if (rtag[i]) ridx = i;
            ok = 1'b0;
            if (ridx >= 0) ok = mv[ridx];
            mis   = ok && rmis;
            e_sq  = '0;
            e_flr = '0;
            e_rtr = '0;
            if (mis) begin
                e_sq = rtag;
                for (int i = 0; i < 4; i++) if (mv[i] && mseq[i] > mseq[ridx]) e_sq[i] = 1'b1;
                e_flr = msnap[ridx];
`ifdef BRANCH_STACK_RETIRE_MERGE_EN
                e_flr = e_flr | rb;
`endif
                e_rtr = mtail[ridx];
            end
            #1;
            chk("rnd_tag", 64'(push_tag), 64'(e_tag));
            chk("rnd_full", 64'(stack_full), 64'(e_full));
            chk("rnd_mask", 64'(branch_mask), 64'(e_mask));
            chk("rnd_rf", 64'(restore_flag), 64'(mis));
            chk("rnd_flr", free_list_restore, e_flr);
            chk("rnd_rtr", 64'(rob_tail_restore), 64'(e_rtr));
            chk("rnd_sq", 64'(squash_mask), 64'(e_sq));

            for (int i = 0; i < 4; i++) if (mv[i]) msnap[i] = msnap[i] | rb;
            if (ok && !rmis) mv[ridx] = 1'b0;
            if (mis) for (int i = 0; i < 4; i++) if (e_sq[i]) mv[i] = 1'b0;
            if (pv && !e_full && !mis) begin
                mv[slot]    = 1'b1;
                msnap[slot] = pfl | rb;
                mtail[slot] = pt;
                mseq[slot]  = seqc;
                seqc++;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        idle();
        tbl[0] = mk(1, 64'h11, 5'd1, 0, 4'h0, 0, 4'b0001, 0, 4'b0000, 0, 64'h0, 5'd0, 4'h0);
        tbl[1] = mk(1, 64'h22, 5'd2, 0, 4'h0, 0, 4'b0010, 0, 4'b0001, 0, 64'h0, 5'd0, 4'h0);
        tbl[2] = mk(1, 64'h44, 5'd3, 0, 4'h0, 0, 4'b0100, 0, 4'b0011, 0, 64'h0, 5'd0, 4'h0);
        tbl[3] = mk(1, 64'h88, 5'd4, 0, 4'h0, 0, 4'b1000, 0, 4'b0111, 0, 64'h0, 5'd0, 4'h0);
        tbl[4] = mk(1, 64'h99, 5'd5, 0, 4'h0, 0, 4'b0000, 1, 4'b1111, 0, 64'h0, 5'd0, 4'h0);
        tbl[5] = mk(0, 64'h0,  5'd0, 0, 4'h0, 0, 4'b0000, 1, 4'b1111, 0, 64'h0, 5'd0, 4'h0);
        tbl[6] = mk(0, 64'h0,  5'd0, 1, 4'b0010, 1, 4'b0000, 1, 4'b1111, 1, 64'h22, 5'd2, 4'b1110);
        tbl[7] = mk(0, 64'h0,  5'd0, 0, 4'h0, 0, 4'b0010, 0, 4'b0001, 0, 64'h0, 5'd0, 4'h0);

        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_in(tbl[k].pv, tbl[k].pfl, tbl[k].pt, tbl[k].rv, tbl[k].rtag, tbl[k].rmis, 2'd0, 6'd0, 6'd0);
            #1;
            chk("tbl_tag", 64'(push_tag), 64'(tbl[k].e_tag));
            chk("tbl_full", 64'(stack_full), 64'(tbl[k].e_full));
            chk("tbl_mask", 64'(branch_mask), 64'(tbl[k].e_mask));
            chk("tbl_rf", 64'(restore_flag), 64'(tbl[k].e_rf));
            chk("tbl_flr", free_list_restore, tbl[k].e_flr);
            chk("tbl_rtr", 64'(rob_tail_restore), 64'(tbl[k].e_rtr));
            chk("tbl_sq", 64'(squash_mask), 64'(tbl[k].e_sq));
            @(negedge clock);
        end

        // Nested mispredict of the middle branch.
        do_reset();
        push(64'h1, 5'd1); push(64'h2, 5'd2); push(64'h4, 5'd3);
        set_in(0, 64'h0, 5'd0, 1, 4'b0010, 1, 2'd0, 6'd0, 6'd0);
        #1;
        chk("nest_rf", 64'(restore_flag), 64'h1);
        chk("nest_flr", free_list_restore, 64'h2);
        chk("nest_sq", 64'(squash_mask), 64'h6);
        @(negedge clock); idle(); #1;
        chk("nest_mask", 64'(branch_mask), 64'h1);

        // Out-of-order correct resolve, then a push colliding with a mispredict.
        do_reset();
        push(64'h1, 5'd1); push(64'h2, 5'd2);
        set_in(0, 64'h0, 5'd0, 1, 4'b0001, 0, 2'd0, 6'd0, 6'd0);
        #1;
        chk("ooo_rf", 64'(restore_flag), 64'h0);
        @(negedge clock); idle(); #1;
        chk("ooo_mask", 64'(branch_mask), 64'h2);
        set_in(1, 64'h3, 5'd3, 1, 4'b0010, 1, 2'd0, 6'd0, 6'd0);
        #1;
        chk("ooo_tag", 64'(push_tag), 64'h1);
        chk("ooo_sq", 64'(squash_mask), 64'h2);
        @(negedge clock); idle(); #1;
        chk("ooo_mask2", 64'(branch_mask), 64'h0);

        // Retirements land in a live snapshot.
        do_reset();
        push(64'h0, 5'd7);
        set_in(0, 64'h0, 5'd0, 0, 4'h0, 0, 2'd2, 6'd5, 6'd9);
        @(negedge clock); @(negedge clock);
        set_in(0, 64'h0, 5'd0, 1, 4'b0001, 1, 2'd0, 6'd0, 6'd0);
        #1;
        chk("ret_flr", free_list_restore, (64'h1 << 5) | (64'h1 << 9));
        chk("ret_rtr", 64'(rob_tail_restore), 64'd7);
        @(negedge clock);

        // Collisions: push with mispredict, push with correct resolve of the only slot.
        do_reset();
        push(64'h1, 5'd1);
        set_in(1, 64'h2, 5'd2, 1, 4'b0001, 1, 2'd0, 6'd0, 6'd0);
        #1;
        chk("col_sq", 64'(squash_mask), 64'h1);
        @(negedge clock); idle(); #1;
        chk("col_drop", 64'(branch_mask), 64'h0);
        push(64'h3, 5'd3);
        set_in(1, 64'h4, 5'd4, 1, 4'b0001, 0, 2'd0, 6'd0, 6'd0);
        #1;
        chk("col_tag", 64'(push_tag), 64'h2);
        @(negedge clock); idle(); #1;
        chk("col_mask", 64'(branch_mask), 64'h2);

        // Invalid resolves are ignored.
        set_in(0, 64'h0, 5'd0, 1, 4'b0011, 1, 2'd0, 6'd0, 6'd0);
        #1;
        chk("bad_hot", 64'({restore_flag, squash_mask}), 64'h0);
        set_in(0, 64'h0, 5'd0, 1, 4'b0100, 1, 2'd0, 6'd0, 6'd0);
        #1;
        chk("bad_inv", 64'({restore_flag, squash_mask}), 64'h0);
        @(negedge clock);

        // Mid-run reset discards checkpoints immediately.
        do_reset();
        push(64'h1, 5'd1); push(64'h2, 5'd2); push(64'h4, 5'd3);
        idle(); #1;
        chk("mid_pre", 64'(branch_mask), 64'h7);
        reset = 1'b0;
        #1;
        chk("mid_mask", 64'(branch_mask), 64'h0);
        chk("mid_tag", 64'(push_tag), 64'h1);
        @(negedge clock);
        reset = 1'b1;
        set_in(1, 64'h5, 5'd5, 0, 4'h0, 0, 2'd0, 6'd0, 6'd0);
        #1;
        chk("mid_ptag", 64'(push_tag), 64'h1);
        @(negedge clock); idle(); #1;
        chk("mid_after", 64'(branch_mask), 64'h1);
        @(negedge clock);

        do_reset();
        random_phase(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
